// File: rtl/tlul_mtimer_pkg.sv
// Register map and response-buffer type for the machine timer.
package tlul_mtimer_pkg;

    localparam logic [4:0] MTIME_LO_OFFSET    = 5'h00;
    localparam logic [4:0] MTIME_HI_OFFSET    = 5'h04;
    localparam logic [4:0] MTIMECMP_LO_OFFSET = 5'h08;
    localparam logic [4:0] MTIMECMP_HI_OFFSET = 5'h0C;
    localparam logic [4:0] CTRL_OFFSET        = 5'h10;
    localparam logic [4:0] PRESCALE_OFFSET    = 5'h14;

    localparam int NUM_REGS  = 6;
    localparam int REG_IDX_W = 3;

    localparam logic [REG_IDX_W-1:0] MTIME_LO_IDX    = MTIME_LO_OFFSET[4:2];
    localparam logic [REG_IDX_W-1:0] MTIME_HI_IDX    = MTIME_HI_OFFSET[4:2];
    localparam logic [REG_IDX_W-1:0] MTIMECMP_LO_IDX = MTIMECMP_LO_OFFSET[4:2];
    localparam logic [REG_IDX_W-1:0] MTIMECMP_HI_IDX = MTIMECMP_HI_OFFSET[4:2];
    localparam logic [REG_IDX_W-1:0] CTRL_IDX        = CTRL_OFFSET[4:2];
    localparam logic [REG_IDX_W-1:0] PRESCALE_IDX    = PRESCALE_OFFSET[4:2];

    localparam int CTRL_EN_BIT = 0;

    typedef struct packed {
        logic [2:0]                  opcode;
        logic [tlul_pkg::TL_AIW-1:0] source;
        logic [tlul_pkg::TL_SZW-1:0] size;
        logic                        error;
        logic [31:0]                 data;
    } rsp_t;

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL type definitions shared by the crossbar-side devices.
package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_SZW = 2;
    localparam int TL_DBW = TL_DW / 8;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic [13:0]       a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        tl_d_user_t        d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_mtimer_core.sv
// Machine timer state: prescaler, 64-bit mtime/mtimecmp, enable and irq.
module tlul_mtimer_core
    import tlul_mtimer_pkg::*;
#(
    parameter int PrescaleW = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 reg_we,
    input  logic [REG_IDX_W-1:0] reg_idx,
    input  logic [31:0]          reg_wdata,
    input  logic [3:0]           reg_wmask,
    output logic [31:0]          reg_rdata,
    output logic                 irq
);

    logic [63:0]          mtime_q, mtime_d, mtime_inc;
    logic [63:0]          mtimecmp_q, mtimecmp_d;
    logic                 en_q, en_d;
    logic [PrescaleW-1:0] prescale_q, prescale_d;
    logic [PrescaleW-1:0] pcnt_q, pcnt_d;
    logic                 pcnt_clr;
    logic                 tick;
    logic                 irq_q;

    // Replace the bytes of old selected by mask with the matching bytes of wdata.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  mask);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) r[8*b +: 8] = wdata[8*b +: 8];
        end
        return r;
    endfunction

    assign tick      = en_q && (pcnt_q == prescale_q);
    assign mtime_inc = mtime_q + {63'b0, tick};

    // Next state: the tick applies first, bus-written bytes override it.
    always_comb begin
        mtime_d    = mtime_inc;
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
        prescale_d = prescale_q;
        pcnt_clr   = 1'b0;
        if (reg_we) begin
            case (reg_idx)
                MTIME_LO_IDX:    mtime_d[31:0]     = merge_bytes(mtime_inc[31:0], reg_wdata, reg_wmask);
                MTIME_HI_IDX:    mtime_d[63:32]    = merge_bytes(mtime_inc[63:32], reg_wdata, reg_wmask);
                MTIMECMP_LO_IDX: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], reg_wdata, reg_wmask);
                MTIMECMP_HI_IDX: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], reg_wdata, reg_wmask);
                CTRL_IDX: begin
                    if (reg_wmask[CTRL_EN_BIT / 8]) begin
                        en_d     = reg_wdata[CTRL_EN_BIT];
                        pcnt_clr = 1'b1;
                    end
                end
                PRESCALE_IDX: begin
                    for (int b = 0; b < PrescaleW; b++) begin
                        if (reg_wmask[b / 8]) prescale_d[b] = reg_wdata[b];
                    end
                    pcnt_clr = 1'b1;
                end
                default: ;
            endcase
        end
        if (pcnt_clr)  pcnt_d = '0;
        else if (tick) pcnt_d = '0;
        else if (en_q) pcnt_d = pcnt_q + PrescaleW'(1);
        else           pcnt_d = pcnt_q;
    end

    // Read mux returns the values held before this cycle's update.
    always_comb begin
        reg_rdata = '0;
        case (reg_idx)
            MTIME_LO_IDX:    reg_rdata = mtime_q[31:0];
            MTIME_HI_IDX:    reg_rdata = mtime_q[63:32];
            MTIMECMP_LO_IDX: reg_rdata = mtimecmp_q[31:0];
            MTIMECMP_HI_IDX: reg_rdata = mtimecmp_q[63:32];
            CTRL_IDX:        reg_rdata[CTRL_EN_BIT] = en_q;
            PRESCALE_IDX:    reg_rdata = 32'(prescale_q);
            default:         reg_rdata = '0;
        endcase
    end

    // Timer state registers; irq compares the already-registered values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            en_q       <= 1'b0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    assign irq = irq_q;

endmodule

// File: rtl/tlul_rsp_intg_gen.sv
// Fills d_user with integrity codes over the response command and data.
module tlul_rsp_intg_gen
    import tlul_pkg::*;
(
    input  tl_d2h_t tl_i,
    output tl_d2h_t tl_o
);

    // Hamming-style check bits plus an overall parity bit over a 57-bit word.
    function automatic logic [6:0] intg7(input logic [56:0] d);
        logic [6:0] p;
        p = '0;
        for (int j = 0; j < 57; j++) begin
            for (int k = 0; k < 6; k++) begin
                if ((((j + 1) >> k) % 2) == 1) p[k] = p[k] ^ d[j];
            end
            p[6] = p[6] ^ d[j];
        end
        return p;
    endfunction

    // Pass the response through, replacing only the integrity fields.
    always_comb begin
        tl_o = tl_i;
        tl_o.d_user.rsp_intg  = intg7({51'b0, tl_i.d_opcode, tl_i.d_size, tl_i.d_error});
        tl_o.d_user.data_intg = intg7({25'b0, tl_i.d_data});
    end

endmodule

// File: rtl/tlul_mtimer.sv
// TL-UL machine timer: request decode, single-entry response buffer, timer core.
module tlul_mtimer
    import tlul_pkg::*;
    import tlul_mtimer_pkg::*;
#(
    parameter int PrescaleW = 16,
    parameter int AddrOffW  = 5
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  tl_h2d_t tl_i,
    output tl_d2h_t tl_o,
    output logic    timer_irq_o
);

    localparam int IdxW = AddrOffW - 2;

    logic                vld_p1;
    rsp_t                rsp_p1;
    rsp_t                rsp_d;
    logic                a_ready;
    logic                accept;
    logic [AddrOffW-1:0] addr_off;
    logic [IdxW-1:0]     word_idx;
    logic                op_get, op_put;
    logic                req_err;
    logic                reg_we;
    logic [31:0]         reg_rdata;
    tl_d2h_t             tl_raw;
    logic                unused_tl;

    assign unused_tl = ^{tl_i.a_param, tl_i.a_user, tl_i.a_address[TL_AW-1:AddrOffW]};

    assign a_ready  = !vld_p1 || tl_i.d_ready;
    assign accept   = tl_i.a_valid && a_ready;
    assign addr_off = tl_i.a_address[AddrOffW-1:0];
    assign word_idx = addr_off[AddrOffW-1:2];
    assign op_get   = (tl_i.a_opcode == Get);
    assign op_put   = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
    assign req_err  = !(op_get || op_put) || (addr_off[1:0] != 2'b00)
                      || (word_idx >= IdxW'(NUM_REGS));
    assign reg_we   = accept && op_put && !req_err;

    tlul_mtimer_core #(
        .PrescaleW (PrescaleW)
    ) u_core (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .reg_we    (reg_we),
        .reg_idx   (word_idx[REG_IDX_W-1:0]),
        .reg_wdata (tl_i.a_data),
        .reg_wmask (tl_i.a_mask),
        .reg_rdata (reg_rdata),
        .irq       (timer_irq_o)
    );

    // Response for the request being accepted this cycle.
    always_comb begin
        rsp_d.opcode = op_get ? AccessAckData : AccessAck;
        rsp_d.source = tl_i.a_source;
        rsp_d.size   = tl_i.a_size;
        rsp_d.error  = req_err;
        rsp_d.data   = (op_get && !req_err) ? reg_rdata : '0;
    end

    // Response-buffer occupancy: fills on accept, drains on d_ready.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)          vld_p1 <= 1'b0;
        else if (accept)      vld_p1 <= 1'b1;
        else if (tl_i.d_ready) vld_p1 <= 1'b0;
    end

    // Response payload, qualified by vld_p1 so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (accept) rsp_p1 <= rsp_d;
    end

    // Assemble the D channel before integrity generation.
    always_comb begin
        tl_raw          = '0;
        tl_raw.d_valid  = vld_p1;
        tl_raw.d_opcode = rsp_p1.opcode;
        tl_raw.d_size   = rsp_p1.size;
        tl_raw.d_source = rsp_p1.source;
        tl_raw.d_data   = rsp_p1.data;
        tl_raw.d_error  = rsp_p1.error;
        tl_raw.a_ready  = a_ready;
    end

    tlul_rsp_intg_gen u_rsp_intg (
        .tl_i (tl_raw),
        .tl_o (tl_o)
    );

endmodule
